// File: rtl/rca_pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits in STAGES slices, carry ripples one slice per clock.
// Latency: result valid STAGES edges after the accepting edge; one operation per cycle.
// Backpressure: a held, unconsumed result freezes every register and drops in_ready (no bubble collapsing).
module rca_pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             stall;
  logic             advance;

  // Operand capture: B is inverted and the carry-in forced to 1 here for subtraction.
  logic             in_v_q;
  logic             in_c_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // Input register: accepts on in_valid & in_ready, bubbles enter as valid=0.
  always_ff @(posedge clk) begin
    if (clr) begin
      in_v_q <= 1'b0;
      in_c_q <= 1'b0;
      in_a_q <= '0;
      in_b_q <= '0;
    end else if (advance) begin
      in_v_q <= in_valid;
      in_c_q <= sub | c_in;
      in_a_q <= a;
      in_b_q <= sub ? ~b : b;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet added (this slice and above) and result bits produced so far.
    localparam int UW = WIDTH - k * SW;
    localparam int RW = (k + 1) * SW;

    logic          v_i;
    logic          c_i;
    logic [UW-1:0] a_u;
    logic [UW-1:0] b_u;
    logic [SW:0]   t;
    logic [RW-1:0] s_n;

    logic          v_q;
    logic          c_q;
    logic [RW-1:0] s_q;

    if (k == 0) begin : g_src
      assign v_i = in_v_q;
      assign c_i = in_c_q;
      assign a_u = in_a_q;
      assign b_u = in_b_q;
      assign s_n = t[SW-1:0];
    end else begin : g_src
      assign v_i = g_stage[k-1].v_q;
      assign c_i = g_stage[k-1].c_q;
      assign a_u = g_stage[k-1].g_skew.a_q;
      assign b_u = g_stage[k-1].g_skew.b_q;
      assign s_n = {t[SW-1:0], g_stage[k-1].s_q};
    end

    // One slice of ripple carry; t[SW] is the carry handed to the next stage.
    assign t = {1'b0, a_u[SW-1:0]} + {1'b0, b_u[SW-1:0]} + {{SW{1'b0}}, c_i};

    // Stage register; the final stage only loads data for valid results so outputs hold across bubbles.
    always_ff @(posedge clk) begin
      if (clr) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_i;
        if (k < LAST || v_i) begin
          c_q <= t[SW];
          s_q <= s_n;
        end
      end
    end

    if (k < LAST) begin : g_skew
      logic [UW-SW-1:0] a_q;
      logic [UW-SW-1:0] b_q;

      // Skew registers carry the operand slices still waiting for their carry.
      always_ff @(posedge clk) begin
        if (clr) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_u[UW-1:SW];
          b_q <= b_u[UW-1:SW];
        end
      end
    end else begin : g_flags
      logic ov_q;
      logic z_q;

      // Flags: carry into the MSB is recovered as a^b'^sum at that bit.
      always_ff @(posedge clk) begin
        if (clr) begin
          ov_q <= 1'b0;
          z_q  <= 1'b0;
        end else if (advance && v_i) begin
          ov_q <= a_u[SW-1] ^ b_u[SW-1] ^ t[SW-1] ^ t[SW];
          z_q  <= ~|s_n;
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].s_q;
  assign c_out     = g_stage[LAST].c_q;
  assign overflow  = g_stage[LAST].g_flags.ov_q;
  assign zero      = g_stage[LAST].g_flags.z_q;

endmodule

// File: tb/tb_rca_pipelined_addsub.sv
// Bench for rca_pipelined_addsub: directed vectors on a 32/4 instance plus
// backpressure, mid-flight reset and a four-configuration random sweep.
module tb_rca_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- main 32-bit / 4-stage instance ----------------
  logic        clr, in_valid, in_ready, c_in, sub, out_valid, out_ready;
  logic        c_out, overflow, zero;
  logic [31:0] a, b, sum;

  rca_pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow), .zero(zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    string       nm;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation alone, measure its latency and check its result.
  task automatic run_vec(input vec_t v);
    int n;
    a = v.a; b = v.b; c_in = v.ci; sub = v.sb; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({v.nm, "_latency"}, 64'(n), 64'd4);
    chk({v.nm, "_sum"},     64'(sum), 64'(v.s));
    chk({v.nm, "_cout"},    64'(c_out), 64'(v.co));
    chk({v.nm, "_ovf"},     64'(overflow), 64'(v.ov));
    chk({v.nm, "_zero"},    64'(zero), 64'(v.z));
    tick();
  endtask

  function automatic logic [34:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
    logic [31:0] yp;
    logic [32:0] full;
    logic        ov;
    yp   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yp} + {32'd0, (sb ? 1'b1 : ci)};
    ov   = (x[31] == yp[31]) && (full[31] != x[31]);
    return {full[32], ov, (full[31:0] == 32'd0), full[31:0]};
  endfunction

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : sweep
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : 64;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2  : (g == 2) ? 8  : 4;

    logic         clr_s, iv, ir, ci, sb, ov_o, ordy, co, ovf, zr;
    logic [W-1:0] aa, bb, ss;
    logic         done = 1'b0;

    rca_pipelined_addsub #(.WIDTH(W), .STAGES(S)) u (
      .clk(clk), .clr(clr_s), .in_valid(iv), .in_ready(ir),
      .a(aa), .b(bb), .c_in(ci), .sub(sb),
      .out_valid(ov_o), .out_ready(ordy),
      .sum(ss), .c_out(co), .overflow(ovf), .zero(zr)
    );

    initial begin : run
      logic [W:0]   full;
      logic [W-1:0] bp;
      logic [63:0]  r1, r2;
      logic [W+2:0] q[$];
      logic [W+2:0] e;
      logic         pstall;
      logic [W-1:0] psum;
      int           sent, n, guard;

      clr_s = 1'b1; iv = 1'b0; ordy = 1'b1; aa = '0; bb = '0; ci = 1'b0; sb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clr_s = 1'b0;

      // Unstalled latency probe: 1 + 2
      aa = W'(1); bb = W'(2); iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      n = 0;
      while (!ov_o && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("sweep%0d_latency", W), 64'(n), 64'(S));
      chk($sformatf("sweep%0d_probe_sum", W), 64'(ss), 64'd3);
      @(posedge clk); #1;

      sent = 0; guard = 0; pstall = 1'b0; psum = '0;
      while ((sent < 1000 || q.size() != 0) && guard < 20000) begin
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        aa   = r1[W-1:0];
        bb   = r2[W-1:0];
        ci   = 1'($urandom_range(1));
        sb   = 1'($urandom_range(1));
        iv   = (sent < 1000) && ($urandom_range(3) != 0);
        ordy = ($urandom_range(3) != 0);
        #1;
        if (pstall)
          chk($sformatf("sweep%0d_hold", W), 64'(ss), 64'(psum));
        if (ov_o && ordy) begin
          if (q.size() == 0) begin
            chk($sformatf("sweep%0d_unexpected_out", W), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("sweep%0d_result", W), 64'({co, ovf, zr}), 64'(e[W+2:W]));
            chk($sformatf("sweep%0d_sum", W), 64'(ss), 64'(e[W-1:0]));
          end
        end
        if (iv && ir) begin
          bp   = sb ? ~bb : bb;
          full = {1'b0, aa} + {1'b0, bp} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
          q.push_back({full[W], (aa[W-1] == bp[W-1]) && (full[W-1] != aa[W-1]),
                       (full[W-1:0] == '0), full[W-1:0]});
          sent++;
        end
        pstall = ov_o && !ordy;
        psum   = ss;
        @(posedge clk); #1;
        guard++;
      end
      iv = 1'b0;
      chk($sformatf("sweep%0d_drained", W), 64'((sent == 1000) && (q.size() == 0)), 64'd1);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ba[8], bbv[8];
    logic        bci[8], bsb[8];
    logic [34:0] exq[$];
    logic [34:0] e;
    logic        acc, cons, pstall, saw;
    logic [31:0] psum;
    int          sent, recvd, g;

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, "carry16"};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, "full_ripple"};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, "pos_ovf"};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow"};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "sub_ovf"};
    vecs[5] = '{32'h55AA55AA, 32'h55AA55AA, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, "sub_equal"};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, "neg_ovf"};
    vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0, "mixed"};

    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_flags",     64'({c_out, overflow, zero}), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Bubbles: outputs hold the last result while out_valid is low.
    tick(); tick();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_hold",  64'(sum), 64'h00000000ACF13568);

    // Backpressure: 8 back-to-back ops, out_ready low for cycles 6..9.
    for (int i = 0; i < 8; i++) begin
      ba[i] = $urandom; bbv[i] = $urandom;
      bci[i] = 1'($urandom_range(1)); bsb[i] = 1'($urandom_range(1));
    end
    sent = 0; recvd = 0; pstall = 1'b0; psum = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 9);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = ba[sent]; b = bbv[sent]; c_in = bci[sent]; sub = bsb[sent];
      end
      #1;
      if (cyc == 6) chk("bp_stalled", 64'(out_valid), 64'd1);
      if (out_valid && !out_ready) chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (pstall) chk("bp_hold", 64'(sum), 64'(psum));
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        if (exq.size() == 0) begin
          chk("bp_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exq.pop_front();
          chk("bp_result", 64'({c_out, overflow, zero, sum}), 64'(e));
          recvd++;
        end
      end
      if (acc) begin
        exq.push_back(model32(ba[sent], bbv[sent], bci[sent], bsb[sent]));
        sent++;
      end
      pstall = out_valid && !out_ready;
      psum   = sum;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 64'(recvd), 64'd8);

    // Reset mid-flight: three ops accepted, clr before any emerges.
    for (int i = 0; i < 3; i++) begin
      a = 32'(i + 10); b = 32'd1; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) saw = 1'b1;
      tick();
    end
    chk("rst_flight_no_out", 64'(saw), 64'd0);
    run_vec('{32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, "post_rst"});

    g = 0;
    while (!(sweep[0].done && sweep[1].done && sweep[2].done && sweep[3].done) && g < 30000) begin
      @(posedge clk);
      g++;
    end
    chk("sweep_finished",
        64'(sweep[0].done && sweep[1].done && sweep[2].done && sweep[3].done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rca_pipelined_addsub.md
Name: rca_pipelined_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor for the datapath ALU. Successor to the fixed 32-bit combinational ripple adder.
- WIDTH bits are split into STAGES equal slices. Each slice is a ripple-carry chain closed by a register, so the carry ripples one slice per clock.
- Adds subtract mode, valid/ready flow control with backpressure, and signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (slices); 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used in add mode only.
- sub  input  1  0 = A+B+c_in; 1 = A-B, i.e. A+~B+1 (c_in ignored).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB. In sub mode, 1 means no borrow (A >= B unsigned).
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset: clr sampled high at a clock edge forces the following, regardless of other inputs.
  - All stage valid bits, out_valid, sum, c_out, overflow and zero go to 0.
  - In-flight operations are discarded and are not output after reset.
  - in_ready is 1 in the cycle after reset.
- Slicing: SW = WIDTH/STAGES.
  - Stage k adds bits [k*SW +: SW] of A and B' (B' = sub ? ~b : b).
  - Its carry-in is the registered carry from stage k-1. Stage 0 takes sub ? 1 : c_in.
  - Upper operand slices travel with the operation in skew registers. Lower result slices are held until the last stage.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, every pipeline register, including outputs, holds its value.
  - Stall is global: no bubble collapsing.
- Transfer: input accepted when in_valid & in_ready at an edge. Output consumed when out_valid & out_ready at an edge.
- Latency: an operation accepted at edge t, with no stall, shows out_valid=1 and its result after edge t+STAGES.
  - Throughput is 1 operation per cycle.
  - STAGES=1 gives a registered single-cycle adder.
- Output stability: outputs change only on an edge where ~stall. A presented result stays stable until it is consumed.
- Pipeline bubbles: bubbles (in_valid=0) propagate as valid=0. When out_valid=0, sum and flags hold their last values.
- Simultaneous consume and accept: when the last stage is consumed in the same cycle a new input is accepted, both happen and the pipeline advances. No result is lost or duplicated.
- Flags come from the final stage only:
  - overflow uses the carry into the MSB (bit WIDTH-1) and the final carry-out.
  - zero is the reduction NOR of the full registered sum.
- Wrap-around: sum is modulo 2^WIDTH; an MSB carry is reported only via c_out.

Test Plan:
- WIDTH=32, STAGES=4, clr then in_valid=1, a=0x0000FFFF, b=0x00000001, c_in=0, sub=0, out_ready=1 -> out_valid=1 exactly 4 cycles after accept; sum=0x00010000, c_out=0, overflow=0, zero=0.
- Add with full carry ripple: a=0xFFFFFFFF, b=0x00000000, c_in=1 -> sum=0x00000000, c_out=1, zero=1, overflow=0. Then a=0x7FFFFFFF, b=1, c_in=0 -> sum=0x80000000, overflow=1, c_out=0.
- Subtract: a=5, b=7, sub=1, c_in=1 (ignored) -> sum=0xFFFFFFFE, c_out=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1, c_out=1.
- Backpressure: stream 8 back-to-back random operations with out_ready low for cycles 6-9 -> in_ready=0 during the stall, the held result stays unchanged, all 8 results arrive in order, with no loss or duplication against a reference model.
- Reset mid-flight: accept 3 operations, assert clr for 1 cycle before any output -> out_valid stays 0 until new inputs; the first post-reset operation 2+3 gives sum=5 after 4 cycles.
- Parameter sweep: (WIDTH,STAGES) = (8,1), (16,2), (32,8), (64,4) with 1000 random add/sub operations and random out_ready -> every result matches a+b+c_in or a-b with correct c_out, overflow and zero; latency equals STAGES cycles when unstalled.
